// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencing a 16-bit load/store/ALU ISA.
// Define CU_SINGLE_STEP_EN to add a step input that holds FETCH until pulsed.
module control_unit #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [15:0]     instr,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_WriteEn,
    output logic            MuxS,
    output logic [3:0]      RegF_W_addr,
    output logic [3:0]      RegF_Ra_addr,
    output logic [3:0]      RegF_Rb_addr,
    output logic            RegF_W_en,
    output logic [2:0]      ALU_S,
    output logic [3:0]      state_out,
    output logic            halted
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_n;
    logic [15:0]     ir;
    logic [15:0]     ir_n;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_n;
    logic            fetch_go;

    logic [7:0]      d_addr_n;
    logic [3:0]      ra_n;
    logic [3:0]      rb_n;
    logic [3:0]      w_n;
    logic            d_we_n;
    logic            rf_we_n;
    logic            muxs_n;
    logic [2:0]      alu_n;

`ifdef CU_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            OP_NOOP:  return NOOP;
            OP_STORE: return STORE;
            OP_LOAD:  return LOAD_A;
            OP_ADD:   return ADD;
            OP_SUB:   return SUB;
            OP_HALT:  return HALT;
            default:  return NOOP;
        endcase
    endfunction

    // Dispatch on the live ROM word so execute starts right after DECODE.
    always_comb begin
        state_n = state;
        ir_n    = ir;
        pc_n    = pc;
        case (state)
            INIT:   state_n = FETCH;
            FETCH:  if (fetch_go) state_n = DECODE;
            DECODE: begin
                ir_n    = instr;
                pc_n    = pc + PC_ONE;
                state_n = dispatch(instr[15:12]);
            end
            LOAD_A: state_n = LOAD_B;
            NOOP, STORE, ADD, SUB, LOAD_B: state_n = FETCH;
            HALT:   state_n = HALT;
            default: state_n = INIT;
        endcase
    end

    // Outputs are computed for the upcoming state and registered with it.
    always_comb begin
        d_addr_n = ir_n[11:4];
        ra_n     = ir_n[11:8];
        rb_n     = ir_n[7:4];
        w_n      = ir_n[3:0];
        d_we_n   = 1'b0;
        rf_we_n  = 1'b0;
        muxs_n   = 1'b0;
        alu_n    = ALU_PASS;
        unique case (1'b1)
            (state_n == LOAD_B): begin
                muxs_n  = 1'b1;
                rf_we_n = 1'b1;
            end
            (state_n == STORE): begin
                ra_n   = ir_n[3:0];
                d_we_n = 1'b1;
            end
            (state_n == ADD): begin
                rf_we_n = 1'b1;
                alu_n   = ALU_ADD;
            end
            (state_n == SUB): begin
                rf_we_n = 1'b1;
                alu_n   = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            ir           <= '0;
            pc           <= '0;
            D_Addr       <= '0;
            RegF_Ra_addr <= '0;
            RegF_Rb_addr <= '0;
            RegF_W_addr  <= '0;
            D_WriteEn    <= 1'b0;
            RegF_W_en    <= 1'b0;
            MuxS         <= 1'b0;
            ALU_S        <= ALU_PASS;
            halted       <= 1'b0;
        end else begin
            state        <= state_n;
            ir           <= ir_n;
            pc           <= pc_n;
            D_Addr       <= d_addr_n;
            RegF_Ra_addr <= ra_n;
            RegF_Rb_addr <= rb_n;
            RegF_W_addr  <= w_n;
            D_WriteEn    <= d_we_n;
            RegF_W_en    <= rf_we_n;
            MuxS         <= muxs_n;
            ALU_S        <= alu_n;
            halted       <= (state_n == HALT);
        end
    end

    assign PC_Addr   = pc;
    assign state_out = state;

endmodule
